// File: rtl/key_debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce_pkg
//  Description : Shared types and defaults for the pushbutton debouncer.
//                Holds the FSM state encoding, the default debounce and
//                auto-repeat timing, and a counter-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package key_debounce_pkg;

    // Debouncer FSM states, fixed 2-bit encoding
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } kdb_state_t;

    // Default timing, in clock cycles
    localparam int unsigned c_STABLE_CYCLES_DEF = 16;
    localparam int unsigned c_REPEAT_DELAY_DEF  = 50_000_000;
    localparam int unsigned c_REPEAT_PERIOD_DEF = 10_000_000;

    // Bits needed for a counter that counts 0 .. max_count-1 (at least 1 bit)
    function automatic int unsigned width_for(input int unsigned max_count);
        int unsigned w;
        w = $clog2(max_count);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-stage synchronizer for a single asynchronous bit.
//                Both stages reset to RESET_VALUE under an asynchronous,
//                active-low clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff
    import key_debounce_pkg::*;
#(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clock,
    input  logic clear,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    // Two back-to-back flops; the first may go metastable, the second resolves it
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_meta <= RESET_VALUE;
            r_sync <= RESET_VALUE;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/key_debounce_pulse.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce_pulse
//  Description : Debounces a raw active-low pushbutton. Each accepted press
//                produces a single-cycle 'pulse'; 'held' follows the
//                debounced pressed level. A level change is accepted only
//                after STABLE_CYCLES consecutive identical synchronized
//                samples.
//                Optional auto-repeat is compiled in with the macro
//                KEY_DEBOUNCE_AUTOREPEAT_EN: while held, extra pulses follow
//                REPEAT_DELAY cycles after the press pulse and then every
//                REPEAT_PERIOD cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_debounce_pulse
    import key_debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = c_STABLE_CYCLES_DEF,
    parameter int unsigned REPEAT_DELAY  = c_REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD = c_REPEAT_PERIOD_DEF
) (
    input  logic clock,
    input  logic clear,
    input  logic key_n,
    output logic pulse,
    output logic held
);

    // Debounce counter runs 0 .. STABLE_CYCLES-1 and never wraps
    localparam int unsigned         c_CNT_W    = width_for(STABLE_CYCLES);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(STABLE_CYCLES - 1);

    logic               w_ks;
    kdb_state_t         r_state;
    kdb_state_t         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               r_pulse;
    logic               w_pulse_nxt;
    logic               r_held;
    logic               w_held_nxt;

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    // Repeat counter covers the longer of the two repeat intervals
    localparam int unsigned c_RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                       : REPEAT_PERIOD;
    localparam int unsigned         c_RPT_W           = width_for(c_RPT_MAX);
    localparam logic [c_RPT_W-1:0]  c_RPT_ONE         = c_RPT_W'(1);
    localparam logic [c_RPT_W-1:0]  c_RPT_DELAY_LAST  = c_RPT_W'(REPEAT_DELAY - 1);
    localparam logic [c_RPT_W-1:0]  c_RPT_PERIOD_LAST = c_RPT_W'(REPEAT_PERIOD - 1);

    logic [c_RPT_W-1:0] r_rpt_cnt;
    logic [c_RPT_W-1:0] w_rpt_cnt_nxt;
    // Set once the initial delay has elapsed; later repeats use the period
    logic               r_rpt_armed;
    logic               w_rpt_armed_nxt;
`else
    // Repeat timing has no effect when auto-repeat is not built in
    logic w_unused_rpt;
    assign w_unused_rpt = (REPEAT_DELAY == 0) ^ (REPEAT_PERIOD == 0);
`endif

    // Resynchronize the raw key; reset to 1 so a reset looks like "released"
    sync_2ff #(
        .RESET_VALUE (1'b1)
    ) u_sync (
        .clock (clock),
        .clear (clear),
        .d     (key_n),
        .q     (w_ks)
    );

    // State, debounce counter and output registers
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
            r_held  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pulse <= w_pulse_nxt;
            r_held  <= w_held_nxt;
        end
    end

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    // Auto-repeat counter and phase flag
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_rpt_cnt   <= '0;
            r_rpt_armed <= 1'b0;
        end else begin
            r_rpt_cnt   <= w_rpt_cnt_nxt;
            r_rpt_armed <= w_rpt_armed_nxt;
        end
    end
`endif

    // Next-state, counter and output decode
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pulse_nxt = 1'b0;           // pulse is always a single cycle
        w_held_nxt  = r_held;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
        // Outside PRESSED the repeat timer is held clear, so every entry
        // into PRESSED starts the full initial delay again
        w_rpt_cnt_nxt   = '0;
        w_rpt_armed_nxt = 1'b0;
`endif

        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (!w_ks) begin
                    w_state_nxt = PRESS_WAIT;
                    w_cnt_nxt   = c_CNT_ONE;
                end
            end

            PRESS_WAIT: begin
                if (w_ks) begin
                    // Bounce: abandon the press silently
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = PRESSED;
                    w_cnt_nxt   = '0;
                    w_pulse_nxt = 1'b1;
                    w_held_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end

            PRESSED: begin
                w_cnt_nxt = '0;
                if (w_ks) begin
                    w_state_nxt = RELEASE_WAIT;
                    w_cnt_nxt   = c_CNT_ONE;
                end
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
                else if (r_rpt_cnt == (r_rpt_armed ? c_RPT_PERIOD_LAST
                                                   : c_RPT_DELAY_LAST)) begin
                    w_pulse_nxt     = 1'b1;
                    w_rpt_cnt_nxt   = '0;
                    w_rpt_armed_nxt = 1'b1;
                end else begin
                    w_rpt_cnt_nxt   = r_rpt_cnt + c_RPT_ONE;
                    w_rpt_armed_nxt = r_rpt_armed;
                end
`endif
            end

            RELEASE_WAIT: begin
                if (!w_ks) begin
                    // Bounce on release: back to pressed without a new pulse
                    w_state_nxt = PRESSED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_held_nxt  = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_held_nxt  = 1'b0;
            end
        endcase
    end

    assign pulse = r_pulse;
    assign held  = r_held;

endmodule
`default_nettype wire
